branch_outcome_tracker: RTL

//  Write side of the 2-bit branch predictor table. Holds each predicted branch from fetch
//  in an in-order queue until the branch resolves in EX.
//  On resolve it drives the predictor update port (update_valid/update_idx/actual_taken).
//  On a misprediction it raises a flush and supplies the redirect PC to fetch.

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_inflight_fifo.sv | 53 +++++
 rtl/branch_outcome_tracker.sv | 119 +++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: default widths, sequential PC step and the in-flight entry layout.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package bp_pkg;

  localparam int BP_ADDR_WIDTH = 8;
  localparam int BP_PC_WIDTH   = 32;
  localparam int PC_STEP       = 4;

  typedef struct packed {
    logic [BP_ADDR_WIDTH-1:0] idx;
    logic                     pred;
    logic [BP_PC_WIDTH-1:0]   pc;
  } bp_entry_t;

  localparam int BP_ENTRY_W = $bits(bp_entry_t);

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted branches with push/pop/clear and an occupancy count.
// Latency: push visible at the head one cycle later; head read is combinational.
// Backpressure: push ignored when full unless dropped by the caller; pop ignored when empty.
module bp_inflight_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_occupancy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_occupancy = r_count;
  assign o_head_dat  = r_mem[r_rd_ptr];
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear && !i_reset) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/branch_outcome_tracker.sv
// Tracks predicted branches until EX resolves them; trains the predictor and redirects fetch on mispredict.
// Latency: update/flush/redirect registered one cycle after the resolve.
// Backpressure: o_push_ready = !full; a mispredict discards the whole queue and any same-cycle push.
module branch_outcome_tracker
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
  parameter int PC_WIDTH   = BP_PC_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int OCC_W     = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [ADDR_WIDTH-1:0] i_push_idx,
  input  logic                  i_push_pred,
  input  logic [PC_WIDTH-1:0]   i_push_pc,
  input  logic                  i_resolve_valid,
  input  logic                  i_resolve_taken,
  input  logic [PC_WIDTH-1:0]   i_resolve_target,
  output logic                  o_update_valid,
  output logic [ADDR_WIDTH-1:0] o_update_idx,
  output logic                  o_actual_taken,
  output logic                  o_flush,
  output logic [PC_WIDTH-1:0]   o_redirect_pc,
  output logic [OCC_W-1:0]      o_occupancy,
  output logic [CNT_WIDTH-1:0]  o_branch_cnt,
  output logic [CNT_WIDTH-1:0]  o_mispred_cnt,
  output logic                  o_err_underflow
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic                  pred;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  entry_t                w_push_ent;
  entry_t                w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_resolve;
  logic                  w_mispred;
  logic                  w_push;
  logic [PC_WIDTH-1:0]   w_redirect;

  logic                  r_update_valid;
  logic [ADDR_WIDTH-1:0] r_update_idx;
  logic                  r_actual_taken;
  logic                  r_flush;
  logic [PC_WIDTH-1:0]   r_redirect_pc;
  logic [CNT_WIDTH-1:0]  r_branch_cnt;
  logic [CNT_WIDTH-1:0]  r_mispred_cnt;
  logic                  r_err_underflow;

  assign w_push_ent = '{idx: i_push_idx, pred: i_push_pred, pc: i_push_pc};
  assign w_resolve  = i_resolve_valid && !w_empty;
  assign w_mispred  = w_resolve && (w_head.pred != i_resolve_taken);
  // Younger entries are wrong-path after a mispredict, so a same-cycle push is dropped too.
  assign w_push     = i_push_valid && !w_full && !w_mispred;
  assign w_redirect = i_resolve_taken ? i_resolve_target : (w_head.pc + PC_WIDTH'(PC_STEP));

  bp_inflight_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_pop       (w_resolve),
    .i_clear     (w_mispred),
    .i_push_dat  (w_push_ent),
    .o_head_dat  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occupancy (o_occupancy)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_update_valid  <= 1'b0;
      r_update_idx    <= '0;
      r_actual_taken  <= 1'b0;
      r_flush         <= 1'b0;
      r_redirect_pc   <= '0;
      r_branch_cnt    <= '0;
      r_mispred_cnt   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_update_valid <= w_resolve;
      r_flush        <= w_mispred;
      if (w_resolve) begin
        r_update_idx   <= w_head.idx;
        r_actual_taken <= i_resolve_taken;
        if (!(&r_branch_cnt)) r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
      end
      if (w_mispred) begin
        r_redirect_pc <= w_redirect;
        if (!(&r_mispred_cnt)) r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
      end
      if (i_resolve_valid && w_empty) r_err_underflow <= 1'b1;
    end
  end

  assign o_push_ready    = !w_full;
  assign o_update_valid  = r_update_valid;
  assign o_update_idx    = r_update_idx;
  assign o_actual_taken  = r_actual_taken;
  assign o_flush         = r_flush;
  assign o_redirect_pc   = r_redirect_pc;
  assign o_branch_cnt    = r_branch_cnt;
  assign o_mispred_cnt   = r_mispred_cnt;
  assign o_err_underflow = r_err_underflow;

endmodule
